instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream stage of the cpu core: holds 128 x 16-bit program memory, fetches sequentially from a PC,
//  buffers words in a small prefetch FIFO and hands {opcode,operand} words to decode via valid/ready.
//  Accepts jump redirects from the core (JMP / conditional jump) and stops fetching after HLT (8'h76).
// PARAMETERS
//  INSTR_W     16   instruction width; [15:8] opcode byte, [7:0] operand byte
//  ADDR_W      7    PC / memory address width (128 words)
//  FIFO_DEPTH  4    prefetch FIFO entries (power of 2, >=2)
// PORTS
//  clk             in   1        system clock, all logic on posedge
//  rst_n           in   1        asynchronous, active-low reset
//  load_en         in   1        program-memory write strobe (honoured only in IDLE or HALT)
//  load_addr       in   ADDR_W   program-memory write address
//  load_data       in   INSTR_W  program-memory write data
//  run             in   1        start fetching from address 0 (sampled in IDLE only)
//  redirect_valid  in   1        jump taken: flush and restart at redirect_pc (any state but IDLE)
//  redirect_pc     in   ADDR_W   jump target
//  instr_valid     out  1        FIFO head holds a valid instruction
//  instr_ready     in   1        decode accepts head this cycle (pop when valid&ready)
//  instr_out       out  INSTR_W  FIFO head instruction word
//  instr_pc        out  ADDR_W   address the head word was fetched from
//  fetch_pc        out  ADDR_W   next address to be issued
//  halted          out  1        HLT fetched and FIFO drained; no further fetch
// BEHAVIOUR
//  Reset (rst_n low, async): state IDLE, fetch_pc=0, FIFO empty, in-flight read cleared; all outputs 0.
//   Memory contents are NOT cleared. Reset mid-fetch drops everything; no instr_valid after release.
//  Memory: synchronous read, 1-cycle latency; a read issued at cycle N lands in the FIFO at edge N+1.
//  States: IDLE -> (run) FETCH; FETCH -> (HLT word written to FIFO) DRAIN;
//   DRAIN -> (FIFO empty) HALT; DRAIN/HALT -> (redirect_valid) FETCH; FETCH -> (redirect) FETCH.
//  Issue rule (FETCH only): issue read at fetch_pc when count + inflight < FIFO_DEPTH, then
//   fetch_pc <= fetch_pc + 1, wrapping 127 -> 0. No issue in IDLE/DRAIN/HALT.
//  HLT: a returning word with [15:8]==8'h76 is pushed, issuing stops; any read already in flight
//   behind it is discarded. halted=1 exactly in HALT.
//  Latency: run high in IDLE at edge E -> read issued cycle after E -> instr_valid high 2 cycles after E.
//   Sustained throughput 1 word/cycle while instr_ready held high.
//  FIFO: push on returning read, pop on instr_valid&instr_ready; simultaneous push+pop keeps count.
//   Full: no issue (guaranteed by issue rule, no overflow). Empty: instr_valid=0, instr_out holds last.
//  Redirect: at that edge FIFO flushed, in-flight read discarded, fetch_pc <= redirect_pc, state FETCH;
//   issue resumes next cycle. Redirect with a same-cycle pop: pop counts as consumed, flush wins.
//   redirect_valid in IDLE ignored.
//  Load: load_en in IDLE/HALT writes mem[load_addr] at the edge; ignored in FETCH/DRAIN.
//   Write and read same address same cycle not possible (reads only in FETCH).
//  run in FETCH/DRAIN/HALT ignored; leaving HALT requires redirect_valid or reset.
// TESTING
//  Load mem[0..3]={3E05,0600,8000,7600}, run, ready=1 -> words out in order, instr_pc 0..3, halted after 4th pop.
//  ready=0 after run -> exactly 4 words buffered, fetch_pc stops at 4; ready=1 -> words 0..3 then 4.. with no loss.
//  Redirect to 7'h40 while FIFO holds 3 words -> next instr_valid word is mem[0x40], none of old 3 emitted.
//  Program of 128 non-HLT words, ready=1 -> instr_pc goes 126,127,0,1 (wrap) without gaps.
//  rst_n low for 1 cycle mid-stream with 2 words buffered -> instr_valid=0, fetch_pc=0, state IDLE immediately.
//  load_en during FETCH to addr 5 with 16'hFFFF -> mem[5] unchanged on later fetch.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Fetch-to-decode instruction handshake (valid/ready + word/pc).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 7
) ();
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    output instr_valid,
    output instr_out,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_out,
    input  instr_pc,
    output instr_ready
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Program memory, sequential PC fetch and prefetch FIFO feeding decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int INSTR_W    = 16,
  parameter int ADDR_W     = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               load_en,
  input  wire logic [ADDR_W-1:0]  load_addr,
  input  wire logic [INSTR_W-1:0] load_data,
  input  wire logic               run,
  input  wire logic               redirect_valid,
  input  wire logic [ADDR_W-1:0]  redirect_pc,
  output      logic [ADDR_W-1:0]  fetch_pc,
  output      logic               halted,
  instr_fetch_unit_if.master      dec
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_mem_d = 2 ** ADDR_W;
  localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(FIFO_DEPTH);
  localparam logic [7:0]         c_hlt_op = 8'h76;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_fetch = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_halt  = 2'd3;

  logic [INSTR_W-1:0] r_mem       [c_mem_d];
  logic [INSTR_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]  r_fifo_pc   [FIFO_DEPTH];

  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_inflight_pc;
  logic [INSTR_W-1:0] r_rd_data;
  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [INSTR_W-1:0] r_last_out;
  logic [ADDR_W-1:0]  r_last_pc;

  logic               w_valid;
  logic               w_pop;
  logic               w_push;
  logic               w_hlt_ret;
  logic               w_redirect;
  logic               w_issue;
  logic               w_load;
  logic [c_cnt_w-1:0] w_occ;

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && dec.instr_ready;
  assign w_push     = r_inflight;
  assign w_hlt_ret  = w_push && (r_rd_data[INSTR_W-1:INSTR_W-8] == c_hlt_op);
  assign w_redirect = redirect_valid && (r_state != c_st_idle);
  assign w_occ      = r_count + c_cnt_w'(r_inflight);
  // A read issued alongside a returning HLT would be discarded anyway, so it is never issued.
  assign w_issue    = (r_state == c_st_fetch) && (w_occ < c_depth) && !w_redirect && !w_hlt_ret;
  assign w_load     = load_en && ((r_state == c_st_idle) || (r_state == c_st_halt));

  assign dec.instr_valid = w_valid;
  assign dec.instr_out   = w_valid ? r_fifo_data[r_rd_ptr] : r_last_out;
  assign dec.instr_pc    = w_valid ? r_fifo_pc[r_rd_ptr]   : r_last_pc;
  assign fetch_pc        = r_fetch_pc;
  assign halted          = (r_state == c_st_halt);

  // Storage arrays carry no reset: memory contents survive rst_n, FIFO slots are masked by r_count.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_mem[load_addr] <= load_data;
    end
    if (w_issue) begin
      r_rd_data <= r_mem[r_fetch_pc];
    end
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= r_rd_data;
      r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_st_idle;
      r_fetch_pc    <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_last_out    <= '0;
      r_last_pc     <= '0;
    end else begin
      if (w_pop) begin
        r_last_out <= r_fifo_data[r_rd_ptr];
        r_last_pc  <= r_fifo_pc[r_rd_ptr];
      end

      if (w_redirect) begin
        r_state    <= c_st_fetch;
        r_fetch_pc <= redirect_pc;
        r_inflight <= 1'b0;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_inflight_pc <= r_fetch_pc;
          r_fetch_pc    <= r_fetch_pc + ADDR_W'(1);
        end

        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + c_cnt_w'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - c_cnt_w'(1);
        end

        case (r_state)
          c_st_idle: begin
            if (run) begin
              r_state <= c_st_fetch;
            end
          end
          c_st_fetch: begin
            if (w_hlt_ret) begin
              r_state <= c_st_drain;
            end
          end
          c_st_drain: begin
            if (r_count == '0) begin
              r_state <= c_st_halt;
            end
          end
          default: begin
            r_state <= c_st_halt;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
